sevenseg_capture: RTL
=====================

// Module: sevenseg_capture
// PURPOSE
//  Reader for the multiplexed 4-digit seven-segment bus that the display path drives through sevenseg.
//  Samples an/a_to_g, filters scan glitches and decodes each pattern back to its 4-bit hex value.
//  Assembles a 16-bit frame for loopback self-check and readback of the distance display.
// PARAMETERS
//  STABLE_CYC   16       cycles an/a_to_g must hold unchanged before a digit is accepted (>=2)
//  TIMEOUT_CYC  2000000  cycles without a completed frame before stale asserts
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  clr_n        in   1   asynchronous, active-low reset
//  an           in   4   digit enables, active-low; exactly one low = one digit selected
//  a_to_g       in   7   segments, active-low; bit6=a ... bit0=g
//  value        out  16  last complete frame; [15:12]=an[3] digit ... [3:0]=an[0] digit
//  blank        out  4   per-digit blank mask of the last frame (pattern 7'b1111111)
//  frame_valid  out  1   1-cycle pulse when value/blank update
//  seg_err      out  1   1-cycle pulse when a stable pattern fails to decode
//  stale        out  1   high while no frame has completed within TIMEOUT_CYC
// BEHAVIOUR
//  - Reset: value=0, blank=4'hF, frame_valid=0, seg_err=0, stale=1, seen=0, FSM=IDLE, counters=0.
//  - an and a_to_g pass through a 2-flop synchronizer; all logic uses the synchronized copies.
//  - Decode table (a_to_g -> nibble): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4
//    0100100=5 0100000=6 0001111=7 0000000=8 0000100=9 0001000=A 1100000=b 0110001=C
//    1000010=d 0110000=E 0111000=F. 1111111=blank. Any other pattern is illegal.
//  - FSM:
//    IDLE: an not one-hot -> stay. One-hot -> load the current sample into the reference,
//      cnt=1, go to COUNT.
//    COUNT: sample == reference -> cnt++. At cnt==STABLE_CYC -> ACCEPT.
//      Any change in the sample -> IDLE on the next cycle; no accept, no error.
//    ACCEPT (1 cycle):
//      legal pattern -> write the nibble (blank -> nibble 0, blank bit 1) into the slot of the
//        low an bit and set that seen bit.
//      illegal pattern -> seg_err pulse; slot and seen bit unchanged.
//      Then go to HOLD.
//    HOLD: wait for the sample to change -> IDLE. A digit held on for a long time is accepted once.
//  - Frame completion: when seen becomes 4'hF, the same cycle copies the slots to value/blank
//    (visible the next cycle). frame_valid pulses with that update, and seen clears to 0.
//  - Rewrite before completion: a slot rewritten before the frame completes keeps the latest value.
//  - Latency: value updates 2 (sync) + STABLE_CYC + 2 cycles after the fourth digit's pattern
//    first appears.
//  - Stale timer:
//    * counts every cycle and saturates at TIMEOUT_CYC.
//    * clears on frame_valid.
//    * stale = (timer == TIMEOUT_CYC).
//    * frame_valid and timer saturation in the same cycle: frame_valid wins, stale=0.
//  - clr_n asserted mid-capture: partial slots and seen bits are discarded; value returns to 0.
// CONFIGURATION
//  DP_EN defined:
//    - adds input dp (1, active-low) and output dp_out (4).
//    - dp is synchronized and stability-checked together with a_to_g.
//    - dp_out[i] is captured with slot i and updates with value.
//  DP_EN undefined: no dp/dp_out ports; dp is ignored entirely.
// STRUCTURE
//  - Shared package sevenseg_pkg:
//    * the 16-entry pattern constants, shared with sevenseg.
//    * SEG_BLANK = 7'b1111111.
//    * FSM state encodings IDLE/COUNT/ACCEPT/HOLD.
//  - One sub-module: sevenseg_decode.
//    * combinational; a_to_g -> {legal, blank, nibble[3:0]}.
//    * the inverse of sevenseg; instantiated once.
// TESTING
//  1. Loopback through sevenseg plus a 4-digit scan driver showing 4'h1A3F, 1 ms per digit
//     -> frame_valid pulses; value=16'h1A3F, blank=0.
//  2. Digit held for only STABLE_CYC-1 cycles between scans -> no accept; that slot stays unseen;
//     no frame_valid.
//  3. an=4'b1110 with a_to_g=7'b1111110 held 20 cycles -> exactly one seg_err pulse; seen[0] stays 0.
//  4. an=4'b1111 or 4'b0011 for 100 cycles -> FSM stays IDLE; no outputs change.
//  5. Digit 2 blanked, others 0,5,7 -> value=16'h0057 (digit 2 slot = 0); blank=4'b0100.
//  6. Stale and reset:
//     - Stop the scan for TIMEOUT_CYC cycles -> stale=1; next full frame -> stale=0.
//     - Pulse clr_n after 2 digits -> value=0, blank=4'hF, and a full new scan is required.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Constants and types shared by the seven-segment display path and its capture reader.
// Segment patterns are active-low with bit6=a ... bit0=g.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Digit selects arrive active-low; callers pass the inverted (active-high) mask.
  function automatic logic sel_onehot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Bundle between the multiplexed display bus and the capture reader.
// Optional decimal-point capture is enabled with DP_EN.
interface sevenseg_capture_if;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        seg_err;
  logic        stale;
`ifdef DP_EN
  logic        dp;
  logic [3:0]  dp_out;

  modport master (
    output an, a_to_g, dp,
    input  value, blank, dp_out, frame_valid, seg_err, stale
  );
  modport slave (
    input  an, a_to_g, dp,
    output value, blank, dp_out, frame_valid, seg_err, stale
  );
`else
  modport master (
    output an, a_to_g,
    input  value, blank, frame_valid, seg_err, stale
  );
  modport slave (
    input  an, a_to_g,
    output value, blank, frame_valid, seg_err, stale
  );
`endif
endinterface

// File: rtl/sevenseg_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> {legal, blank, nibble}.
// A blank pattern is legal and reports nibble 0.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_seg == SEG_BLANK) begin
      o_dec.legal = 1'b1;
      o_dec.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i_seg == SEG_PAT[i]) begin
          o_dec.legal  = 1'b1;
          o_dec.nibble = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Reads back the multiplexed 4-digit display bus into a 16-bit frame with glitch filtering.
// Define DP_EN to also capture the per-digit decimal point.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              clr_n,
  sevenseg_capture_if.slave cap_bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYC);
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYC);

  logic [3:0]    r_an_s1, r_an_s2;
  logic [6:0]    r_seg_s1, r_seg_s2;
  cap_state_e    r_state, w_state_nxt;
  logic [3:0]    r_ref_an;
  logic [6:0]    r_ref_seg;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_slot, w_slot_nxt;
  logic [3:0]    r_slot_blank, w_blank_nxt;
  logic [3:0]    r_seen, w_seen_nxt;
  logic [15:0]   r_value;
  logic [3:0]    r_blank;
  logic          r_frame_valid, r_seg_err, r_stale;
  logic [TW-1:0] r_timer, w_timer_nxt;

  logic          w_onehot, w_same, w_cnt_done;
  logic          w_ld_ref, w_cnt_inc, w_accept, w_wr, w_frame_done;
  logic [3:0]    w_sel;
  logic [1:0]    w_idx;
  seg_dec_t      w_dec;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_an_s1  <= 4'hF;
      r_an_s2  <= 4'hF;
      r_seg_s1 <= SEG_BLANK;
      r_seg_s2 <= SEG_BLANK;
    end else begin
      r_an_s1  <= cap_bus.an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= cap_bus.a_to_g;
      r_seg_s2 <= r_seg_s1;
    end
  end

`ifdef DP_EN
  logic       r_dp_s1, r_dp_s2, r_ref_dp;
  logic [3:0] r_dp_slot, w_dp_nxt, r_dp_out;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_dp_s1 <= 1'b1;
      r_dp_s2 <= 1'b1;
    end else begin
      r_dp_s1 <= cap_bus.dp;
      r_dp_s2 <= r_dp_s1;
    end
  end

  assign w_same = (r_an_s2 == r_ref_an) && (r_seg_s2 == r_ref_seg) && (r_dp_s2 == r_ref_dp);
`else
  assign w_same = (r_an_s2 == r_ref_an) && (r_seg_s2 == r_ref_seg);
`endif

  assign w_onehot   = sel_onehot(~r_an_s2);
  assign w_cnt_done = (r_cnt == CNT_DONE);

  // state  | meaning
  // IDLE   | no single digit selected, or the sample just changed
  // COUNT  | candidate pattern latched, counting stable cycles
  // ACCEPT | pattern stable long enough; decode and store it
  // HOLD   | digit already taken; wait for the bus to move on
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_onehot) w_state_nxt = COUNT;
      COUNT: begin
        if (!w_same)         w_state_nxt = IDLE;
        else if (w_cnt_done) w_state_nxt = ACCEPT;
      end
      ACCEPT:  w_state_nxt = HOLD;
      HOLD:    if (!w_same) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ld_ref  = (r_state == IDLE) && w_onehot;
    w_cnt_inc = (r_state == COUNT) && w_same && !w_cnt_done;
    w_accept  = (r_state == ACCEPT);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ref_an  <= 4'hF;
      r_ref_seg <= SEG_BLANK;
      r_cnt     <= '0;
    end else if (w_ld_ref) begin
      r_ref_an  <= r_an_s2;
      r_ref_seg <= r_seg_s2;
      r_cnt     <= CW'(1);
    end else if (w_cnt_inc) begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

`ifdef DP_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)        r_ref_dp <= 1'b1;
    else if (w_ld_ref) r_ref_dp <= r_dp_s2;
  end
`endif

  sevenseg_decode u_decode (
    .i_seg (r_ref_seg),
    .o_dec (w_dec)
  );

  assign w_sel = ~r_ref_an;
  assign w_idx = sel_index(w_sel);
  assign w_wr  = w_accept && w_dec.legal;

  // The completing digit is merged combinationally so value sees it in the same update.
  always_comb begin
    w_slot_nxt  = r_slot;
    w_blank_nxt = r_slot_blank;
    w_seen_nxt  = r_seen;
    if (w_wr) begin
      w_slot_nxt[{w_idx, 2'b00} +: 4] = w_dec.nibble;
      w_blank_nxt[w_idx]              = w_dec.blank;
      w_seen_nxt                      = r_seen | w_sel;
    end
  end

  assign w_frame_done = w_wr && (w_seen_nxt == 4'hF);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_slot        <= '0;
      r_slot_blank  <= 4'hF;
      r_seen        <= '0;
      r_value       <= '0;
      r_blank       <= 4'hF;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
    end else begin
      r_slot        <= w_slot_nxt;
      r_slot_blank  <= w_blank_nxt;
      r_seen        <= w_frame_done ? 4'h0 : w_seen_nxt;
      r_frame_valid <= w_frame_done;
      r_seg_err     <= w_accept && !w_dec.legal;
      if (w_frame_done) begin
        r_value <= w_slot_nxt;
        r_blank <= w_blank_nxt;
      end
    end
  end

`ifdef DP_EN
  always_comb begin
    w_dp_nxt = r_dp_slot;
    if (w_wr) w_dp_nxt[w_idx] = r_ref_dp;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_dp_slot <= 4'hF;
      r_dp_out  <= 4'hF;
    end else begin
      r_dp_slot <= w_dp_nxt;
      if (w_frame_done) r_dp_out <= w_dp_nxt;
    end
  end

  assign cap_bus.dp_out = r_dp_out;
`endif

  // Stale is sticky from reset until the first frame, then tracks timer saturation.
  assign w_timer_nxt = w_frame_done ? '0 :
                       (r_timer == TMO) ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_timer <= '0;
      r_stale <= 1'b1;
    end else begin
      r_timer <= w_timer_nxt;
      r_stale <= !w_frame_done && (r_stale || (w_timer_nxt == TMO));
    end
  end

  assign cap_bus.value       = r_value;
  assign cap_bus.blank       = r_blank;
  assign cap_bus.frame_valid = r_frame_valid;
  assign cap_bus.seg_err     = r_seg_err;
  assign cap_bus.stale       = r_stale;

endmodule
